// File: rtl/wam_score_counter_pkg.sv
// rtl/wam_score_counter_pkg.sv - shared types and helpers for the Whack-A-Mole score keeper
package wam_pkg;

  localparam logic [3:0] BLANK_CODE = 4'd10;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  // Packed BCD orders exactly like unsigned binary when compared MSB digit first.
  function automatic logic bcd_gt(input logic [63:0] a, input logic [63:0] b);
    return a > b;
  endfunction

endpackage

// File: rtl/wam_score_counter_digit_cell.sv
// rtl/wam_score_counter_digit_cell.sv - one BCD digit with ripple carry/borrow
module bcd_digit_cell
  import wam_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       inc,
  input  logic       dec,
  input  logic       carry_in,
  input  logic       borrow_in,
  output bcd_digit_t digit_next,
  output logic       carry_out,
  output logic       borrow_out
);

  logic step_up;
  logic step_down;

  assign step_up    = inc & carry_in;
  assign step_down  = dec & borrow_in;
  assign carry_out  = step_up & (digit == 4'd9);
  assign borrow_out = step_down & (digit == 4'd0);

  always_comb begin
    digit_next = digit;
    if (step_up) begin
      digit_next = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    end else if (step_down) begin
      digit_next = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
    end
  end

endmodule

// File: rtl/wam_score_counter.sv
// rtl/wam_score_counter.sv - saturating BCD score/high-score keeper with blanked display output
module wam_score_counter
  import wam_pkg::*;
#(
  parameter int         DIGITS        = 4,
  parameter logic [3:0] BLANK_CODE    = wam_pkg::BLANK_CODE,
  parameter int         LEADING_BLANK = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                hit,
  input  logic                penalty,
  input  logic                game_over,
  input  logic                show_high,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic [4*DIGITS-1:0] high_bcd,
  output logic [4*DIGITS-1:0] disp_bcd,
  output logic                saturated,
  output logic                frozen,
  output logic                new_high
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_e         state_q, state_d;
  logic [W-1:0]   score_q, score_d;
  logic [W-1:0]   high_q, high_d;
  logic [W-1:0]   disp_q, disp_d;
  logic           new_high_q, new_high_d;

  logic [W-1:0]   score_next;
  logic [DIGITS:0] carry;
  logic [DIGITS:0] borrow;
  logic           is_max, is_zero, counting, inc, dec;

  assign is_max   = (score_q == ALL_NINES);
  assign is_zero  = (score_q == '0);
  // clear and game_over both take priority over this cycle's hit/penalty.
  assign counting = (state_q == RUN) & ~clear & ~game_over;
  assign inc      = counting & hit & ~penalty & ~is_max;
  assign dec      = counting & penalty & ~hit & ~is_zero;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_cell
    bcd_digit_cell u_cell (
      .digit      (score_q[4*i +: 4]),
      .inc        (inc),
      .dec        (dec),
      .carry_in   (carry[i]),
      .borrow_in  (borrow[i]),
      .digit_next (score_next[4*i +: 4]),
      .carry_out  (carry[i+1]),
      .borrow_out (borrow[i+1])
    );
  end

  always_comb begin
    state_d    = state_q;
    high_d     = high_q;
    new_high_d = 1'b0;
    // A wrap out of the top digit is already prevented by gating; hold as a backstop.
    score_d    = (carry[DIGITS] | borrow[DIGITS]) ? score_q : score_next;
    if (clear) begin
      score_d = '0;
      state_d = RUN;
    end else if (game_over && state_q == RUN) begin
      score_d = score_q;
      state_d = FROZEN;
      if (bcd_gt(64'(score_q), 64'(high_q))) begin
        high_d     = score_q;
        new_high_d = 1'b1;
      end
    end
  end

  always_comb begin : blank_blk
    logic [W-1:0] sel;
    logic         lead;
    sel    = show_high ? high_d : score_d;
    lead   = (LEADING_BLANK != 0);
    disp_d = sel;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && sel[4*i +: 4] == 4'd0) begin
        disp_d[4*i +: 4] = BLANK_CODE;
      end else begin
        lead = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RUN;
      score_q    <= '0;
      high_q     <= '0;
      new_high_q <= 1'b0;
      disp_q     <= (LEADING_BLANK != 0) ? {{(DIGITS-1){BLANK_CODE}}, 4'd0} : '0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
      disp_q     <= disp_d;
    end
  end

  assign score_bcd = score_q;
  assign high_bcd  = high_q;
  assign disp_bcd  = disp_q;
  assign new_high  = new_high_q;
  assign saturated = is_max;
  assign frozen    = (state_q == FROZEN);

endmodule

// File: tb/tb_wam_score_counter.sv
// tb/tb_wam_score_counter.sv - directed self-checking bench for wam_score_counter
module tb_wam_score_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        hit = 1'b0;
  logic        penalty = 1'b0;
  logic        game_over = 1'b0;
  logic        show_high = 1'b0;
  logic [15:0] score_bcd, high_bcd, disp_bcd;
  logic        saturated, frozen, new_high;

  int pass_cnt = 0;
  int total_cnt = 0;

  wam_score_counter #(.DIGITS(4), .BLANK_CODE(4'd10), .LEADING_BLANK(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .hit       (hit),
    .penalty   (penalty),
    .game_over (game_over),
    .show_high (show_high),
    .score_bcd (score_bcd),
    .high_bcd  (high_bcd),
    .disp_bcd  (disp_bcd),
    .saturated (saturated),
    .frozen    (frozen),
    .new_high  (new_high)
  );

  always #5 clk = ~clk;

  // Inputs change at the falling edge; the following falling edge sees the result.
  task automatic cyc(input logic h, input logic p, input logic go, input logic clr);
    hit = h; penalty = p; game_over = go; clear = clr;
    @(negedge clk);
    hit = 1'b0; penalty = 1'b0; game_over = 1'b0; clear = 1'b0;
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pens(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) @(negedge clk);
    total_cnt++; if (score_bcd !== 16'h0000) $display("FAIL reset_score got %h exp 0000", score_bcd); else pass_cnt++;
    total_cnt++; if (disp_bcd !== 16'hAAA0) $display("FAIL reset_disp got %h exp AAA0", disp_bcd); else pass_cnt++;
    total_cnt++; if (high_bcd !== 16'h0000) $display("FAIL reset_high got %h exp 0000", high_bcd); else pass_cnt++;
    total_cnt++; if ({frozen, new_high, saturated} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {frozen, new_high, saturated}); else pass_cnt++;
  endtask

  task automatic test_count();
    hits(12);
    total_cnt++; if (score_bcd !== 16'h0012) $display("FAIL count_up got %h exp 0012", score_bcd); else pass_cnt++;
    total_cnt++; if (disp_bcd !== 16'hAA12) $display("FAIL count_up_disp got %h exp AA12", disp_bcd); else pass_cnt++;
    pens(3);
    total_cnt++; if (score_bcd !== 16'h0009) $display("FAIL count_down got %h exp 0009", score_bcd); else pass_cnt++;
    total_cnt++; if (disp_bcd !== 16'hAAA9) $display("FAIL count_down_disp got %h exp AAA9", disp_bcd); else pass_cnt++;
    pens(10);
    total_cnt++; if (score_bcd !== 16'h0000) $display("FAIL floor got %h exp 0000", score_bcd); else pass_cnt++;
    total_cnt++; if (disp_bcd !== 16'hAAA0) $display("FAIL floor_disp got %h exp AAA0", disp_bcd); else pass_cnt++;
  endtask

  task automatic test_carry();
    hits(199);
    total_cnt++; if (score_bcd !== 16'h0199) $display("FAIL pre_carry got %h exp 0199", score_bcd); else pass_cnt++;
    hits(1);
    total_cnt++; if (score_bcd !== 16'h0200) $display("FAIL carry got %h exp 0200", score_bcd); else pass_cnt++;
    pens(1);
    total_cnt++; if (score_bcd !== 16'h0199) $display("FAIL borrow got %h exp 0199", score_bcd); else pass_cnt++;
  endtask

  task automatic test_saturate();
    hits(9799);
    total_cnt++; if (score_bcd !== 16'h9998) $display("FAIL preload got %h exp 9998", score_bcd); else pass_cnt++;
    total_cnt++; if (saturated !== 1'b0) $display("FAIL sat_below got %b exp 0", saturated); else pass_cnt++;
    hits(1);
    total_cnt++; if ({saturated, score_bcd} !== {1'b1, 16'h9999}) $display("FAIL sat_reach got %b/%h exp 1/9999", saturated, score_bcd); else pass_cnt++;
    hits(1);
    total_cnt++; if ({saturated, score_bcd} !== {1'b1, 16'h9999}) $display("FAIL sat_hold got %b/%h exp 1/9999", saturated, score_bcd); else pass_cnt++;
    pens(1);
    total_cnt++; if ({saturated, score_bcd} !== {1'b0, 16'h9998}) $display("FAIL sat_leave got %b/%h exp 0/9998", saturated, score_bcd); else pass_cnt++;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    hits(150);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    total_cnt++; if (score_bcd !== 16'h0150) $display("FAIL hit_and_pen got %h exp 0150", score_bcd); else pass_cnt++;
  endtask

  task automatic test_game_over();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    hits(42);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    total_cnt++; if ({frozen, new_high, high_bcd} !== {2'b11, 16'h0042}) $display("FAIL go_first got %b%b/%h exp 11/0042", frozen, new_high, high_bcd); else pass_cnt++;
    hits(3);
    total_cnt++; if ({new_high, score_bcd} !== {1'b0, 16'h0042}) $display("FAIL frozen_hold got %b/%h exp 0/0042", new_high, score_bcd); else pass_cnt++;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    total_cnt++; if ({frozen, score_bcd} !== {1'b0, 16'h0000}) $display("FAIL clear_frozen got %b/%h exp 0/0000", frozen, score_bcd); else pass_cnt++;
    hits(30);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    total_cnt++; if ({frozen, new_high, high_bcd} !== {2'b10, 16'h0042}) $display("FAIL go_lower got %b%b/%h exp 10/0042", frozen, new_high, high_bcd); else pass_cnt++;
    show_high = 1'b1;
    @(negedge clk);
    total_cnt++; if (disp_bcd !== 16'hAA42) $display("FAIL show_high got %h exp AA42", disp_bcd); else pass_cnt++;
    show_high = 1'b0;
    @(negedge clk);
    total_cnt++; if (disp_bcd !== 16'hAA30) $display("FAIL show_score got %h exp AA30", disp_bcd); else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    do_reset();
    hits(7);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    total_cnt++; if ({score_bcd, high_bcd} !== {16'h0007, 16'h0007}) $display("FAIL hit_go got %h/%h exp 0007/0007", score_bcd, high_bcd); else pass_cnt++;
    total_cnt++; if ({frozen, new_high} !== 2'b11) $display("FAIL hit_go_flags got %b exp 11", {frozen, new_high}); else pass_cnt++;
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    total_cnt++; if ({frozen, score_bcd, high_bcd} !== {1'b0, 16'h0000, 16'h0007}) $display("FAIL clr_go_frozen got %b/%h/%h exp 0/0000/0007", frozen, score_bcd, high_bcd); else pass_cnt++;
    hits(20);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    total_cnt++; if ({frozen, new_high, score_bcd, high_bcd} !== {2'b00, 16'h0000, 16'h0007}) $display("FAIL clr_go_run got %b%b/%h/%h exp 00/0000/0007", frozen, new_high, score_bcd, high_bcd); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    hits(500);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    hits(123);
    total_cnt++; if ({score_bcd, high_bcd} !== {16'h0123, 16'h0500}) $display("FAIL mid_setup got %h/%h exp 0123/0500", score_bcd, high_bcd); else pass_cnt++;
    reset = 1'b0; hit = 1'b1; game_over = 1'b1;
    @(negedge clk);
    reset = 1'b1; hit = 1'b0; game_over = 1'b0;
    total_cnt++; if ({score_bcd, high_bcd, disp_bcd} !== {16'h0000, 16'h0000, 16'hAAA0}) $display("FAIL mid_reset got %h/%h/%h exp 0000/0000/AAA0", score_bcd, high_bcd, disp_bcd); else pass_cnt++;
    total_cnt++; if ({frozen, new_high, saturated} !== 3'b000) $display("FAIL mid_reset_flags got %b exp 000", {frozen, new_high, saturated}); else pass_cnt++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_count();
    test_carry();
    test_saturate();
    test_game_over();
    test_same_cycle();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
